// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for the shared instruction/data memory port
//
// Purpose:
//   Grants at most one of two requesters per cycle onto a single memory port.
//   M0 (CPU fetch/load/store) has fixed priority. M1 (loader/debug DMA) wins
//   after MAX_WAIT stalled cycles, or while it holds the port with m1_lock.
//   Read data returns one cycle after a read grant, tagged by mX_rvalid.
//
// Optional feature:
//   MEM_ARB_RR_EN - when defined, fixed priority and the starvation counter
//   are replaced by round-robin between M0 and M1 (lock is still honoured).
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   m0_req/we/addr/wd                 M0 request, held until m0_gnt
//   m0_gnt, m0_stall                  M0 accepted / waiting
//   m0_rvalid, m0_rdata               M0 read response
//   m1_req/we/addr/wd, m1_lock        M1 request, lock across transfers
//   m1_gnt, m1_rvalid, m1_rdata       M1 accepted / read response
//   mem_addr, mem_we, mem_wd, mem_rd  memory port, mem_rd valid 1 cycle later

module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_gnt,
  output logic          m0_stall,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wd,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic lock_q, lock_d;
  logic m0_rvalid_q, m0_rvalid_d;
  logic m1_rvalid_q, m1_rvalid_d;

`ifdef MEM_ARB_RR_EN
  // 1 = M1 was granted last, 0 = M0. Resets to M1 so M0 goes first.
  logic rr_last_q, rr_last_d;
`else
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Grant decision. Reset forces both grants low so nothing reaches memory.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
`ifdef MEM_ARB_RR_EN
      if (lock_q) begin
        // Locked port belongs to M1; M0 waits even if M1 just dropped req.
        m1_gnt = m1_req;
      end else if (m0_req && m1_req) begin
        m0_gnt = rr_last_q;
        m1_gnt = ~rr_last_q;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
`else
      if (m1_req && (lock_q || wait_cnt_q == WAIT_MAX)) begin
        m1_gnt = 1'b1;
      end else if (m0_req && !lock_q) begin
        m0_gnt = 1'b1;
      end else if (m1_req) begin
        m1_gnt = 1'b1;
      end
`endif
    end
  end

  assign m0_stall = m0_req & ~m0_gnt;

  // Memory port mux; idle port drives all zeros.
  always_comb begin
    mem_addr = '0;
    mem_we   = 1'b0;
    mem_wd   = '0;
    if (m0_gnt) begin
      mem_addr = m0_addr;
      mem_we   = m0_we;
      mem_wd   = m0_wd;
    end else if (m1_gnt) begin
      mem_addr = m1_addr;
      mem_we   = m1_we;
      mem_wd   = m1_wd;
    end
  end

  // Next-state for lock, response strobes and priority state.
  always_comb begin
    lock_d = lock_q;
    if (m1_gnt && m1_lock) begin
      lock_d = 1'b1;
    end
    if (!m1_lock || !m1_req) begin
      lock_d = 1'b0;
    end

    m0_rvalid_d = m0_gnt & ~m0_we;
    m1_rvalid_d = m1_gnt & ~m1_we;

`ifdef MEM_ARB_RR_EN
    rr_last_d = rr_last_q;
    if (m0_gnt) begin
      rr_last_d = 1'b0;
    end else if (m1_gnt) begin
      rr_last_d = 1'b1;
    end
`else
    wait_cnt_d = wait_cnt_q;
    if (m1_gnt || !m1_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= 1'b1;
`else
      wait_cnt_q  <= '0;
`endif
    end else begin
      lock_q      <= lock_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
`ifdef MEM_ARB_RR_EN
      rr_last_q   <= rr_last_d;
`else
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  // Response is tagged by the registered strobe, so a new grant in the same
  // cycle cannot steal the returning data.
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rvalid_q ? mem_rd : '0;
  assign m1_rdata  = m1_rvalid_q ? mem_rd : '0;

endmodule
